// File: rtl/enc_pkg.sv
// Shared types and constants for the 8-to-3 serial priority encoder.
// The state enum, the bus widths and a small bit-count helper live here.
package enc_pkg;

    localparam int N_IN   = 8;
    localparam int N_CODE = 3;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // True when no more than one bit of v is set.
    function automatic logic at_most_one(input logic [N_IN-1:0] v);
        return ((v & (v - N_IN'(1))) == '0);
    endfunction

endpackage

// File: rtl/enc8x3_serial_if.sv
// Request/code bus of enc8x3_serial.
// The master drives vectors and consumer readiness; the slave returns codes.
interface enc8x3_serial_if;
    import enc_pkg::*;

    logic [N_IN-1:0]   req;
    logic              req_valid;
    logic              req_ready;
    logic [N_CODE-1:0] code;
    logic              code_valid;
    logic              out_ready;
    logic              last;
    logic              err_zero;

    modport master (
        output req, req_valid, out_ready,
        input  req_ready, code, code_valid, last, err_zero
    );

    modport slave (
        input  req, req_valid, out_ready,
        output req_ready, code, code_valid, last, err_zero
    );

endinterface

// File: rtl/prio_enc8.sv
// Combinational 8-bit priority encoder returning the index of the winning bit.
// PRIO_MSB=1 gives bit 7 the highest priority, PRIO_MSB=0 gives bit 0 the highest.
module prio_enc8
    import enc_pkg::*;
#(
    parameter int PRIO_MSB = 1
) (
    input  logic [N_IN-1:0]   vec,
    output logic [N_CODE-1:0] idx,
    output logic              any_set
);

    // Scan in the direction where the highest-priority bit is visited last.
    always_comb begin
        idx     = '0;
        any_set = |vec;
        if (PRIO_MSB != 0) begin
            for (int i = 0; i < N_IN; i++) begin
                if (vec[i]) idx = N_CODE'(i);
            end
        end else begin
            for (int i = N_IN - 1; i >= 0; i--) begin
                if (vec[i]) idx = N_CODE'(i);
            end
        end
    end

endmodule

// File: rtl/enc8x3_serial.sv
// Accepts an 8-bit request vector and emits the index of each set bit,
// one per handshake, in priority order; all-zero vectors raise err_zero.
module enc8x3_serial
    import enc_pkg::*;
#(
    parameter int PRIO_MSB = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    enc8x3_serial_if.slave  bus
);

    state_t            state;
    state_t            next_state;
    logic [N_IN-1:0]   pending;
    logic [N_IN-1:0]   pending_next;
    logic              err_zero_q;
    logic              err_zero_next;
    logic [N_CODE-1:0] enc_idx;
    logic              any_set;
    logic              last_int;

    prio_enc8 #(
        .PRIO_MSB (PRIO_MSB)
    ) u_prio (
        .vec     (pending),
        .idx     (enc_idx),
        .any_set (any_set)
    );

    assign last_int       = (state == EMIT) && any_set && at_most_one(pending);
    assign bus.last       = last_int;
    assign bus.code_valid = (state == EMIT);
    assign bus.req_ready  = (state == IDLE);
    assign bus.code       = (state == EMIT) ? enc_idx : '0;
    assign bus.err_zero   = err_zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pending    <= '0;
            err_zero_q <= 1'b0;
        end else begin
            state      <= next_state;
            pending    <= pending_next;
            err_zero_q <= err_zero_next;
        end
    end

    // Requests are only looked at in IDLE; in EMIT each handshake retires the current code.
    always_comb begin
        next_state    = state;
        pending_next  = pending;
        err_zero_next = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    pending_next = bus.req;
                    if (bus.req != '0) next_state = EMIT;
                    else err_zero_next = 1'b1;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    pending_next = pending & ~(N_IN'(1) << enc_idx);
                    if (last_int) next_state = IDLE;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_enc8x3_serial.sv
// Directed bench for enc8x3_serial: one DUT with MSB priority, one with LSB priority.
module tb_enc8x3_serial;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    enc8x3_serial_if m_if ();
    enc8x3_serial_if l_if ();

    enc8x3_serial #(.PRIO_MSB(1)) dut_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m_if.slave)
    );

    enc8x3_serial #(.PRIO_MSB(0)) dut_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (l_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (m_if.req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%0b want=1", m_if.req_ready); end
        total++;
        if (m_if.code_valid !== 1'b0 || m_if.code !== 3'd0) begin
            bad++; $display("FAIL rst_code got valid=%0b code=%0d want valid=0 code=0", m_if.code_valid, m_if.code);
        end
        total++;
        if (m_if.last !== 1'b0 || m_if.err_zero !== 1'b0) begin
            bad++; $display("FAIL rst_flags got last=%0b err=%0b want 0 0", m_if.last, m_if.err_zero);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_msb_order();
        m_if.req = 8'h81; m_if.req_valid = 1'b1; m_if.out_ready = 1'b1;
        @(negedge clk);
        m_if.req_valid = 1'b0;
        total++;
        if (m_if.code_valid !== 1'b1 || m_if.code !== 3'd7 || m_if.last !== 1'b0 || m_if.req_ready !== 1'b0) begin
            bad++; $display("FAIL msb_first got v=%0b code=%0d last=%0b rdy=%0b want 1 7 0 0",
                            m_if.code_valid, m_if.code, m_if.last, m_if.req_ready);
        end
        @(negedge clk);
        total++;
        if (m_if.code_valid !== 1'b1 || m_if.code !== 3'd0 || m_if.last !== 1'b1) begin
            bad++; $display("FAIL msb_second got v=%0b code=%0d last=%0b want 1 0 1",
                            m_if.code_valid, m_if.code, m_if.last);
        end
        @(negedge clk);
        total++;
        if (m_if.req_ready !== 1'b1 || m_if.code_valid !== 1'b0 || m_if.code !== 3'd0) begin
            bad++; $display("FAIL msb_idle got rdy=%0b v=%0b code=%0d want 1 0 0",
                            m_if.req_ready, m_if.code_valid, m_if.code);
        end
    endtask

    task automatic test_lsb_order();
        l_if.req = 8'h24; l_if.req_valid = 1'b1; l_if.out_ready = 1'b1;
        @(negedge clk);
        l_if.req_valid = 1'b0;
        total++;
        if (l_if.code_valid !== 1'b1 || l_if.code !== 3'd2 || l_if.last !== 1'b0) begin
            bad++; $display("FAIL lsb_first got v=%0b code=%0d last=%0b want 1 2 0",
                            l_if.code_valid, l_if.code, l_if.last);
        end
        @(negedge clk);
        total++;
        if (l_if.code_valid !== 1'b1 || l_if.code !== 3'd5 || l_if.last !== 1'b1) begin
            bad++; $display("FAIL lsb_second got v=%0b code=%0d last=%0b want 1 5 1",
                            l_if.code_valid, l_if.code, l_if.last);
        end
        @(negedge clk);
        total++;
        if (l_if.req_ready !== 1'b1 || l_if.code_valid !== 1'b0) begin
            bad++; $display("FAIL lsb_idle got rdy=%0b v=%0b want 1 0", l_if.req_ready, l_if.code_valid);
        end
    endtask

    task automatic test_stall();
        m_if.req = 8'h10; m_if.req_valid = 1'b1; m_if.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            m_if.req_valid = 1'b0;
            total++;
            if (m_if.code_valid !== 1'b1 || m_if.code !== 3'd4 || m_if.last !== 1'b1) begin
                bad++; $display("FAIL stall_hold cycle=%0d got v=%0b code=%0d last=%0b want 1 4 1",
                                c, m_if.code_valid, m_if.code, m_if.last);
            end
        end
        m_if.out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (m_if.code_valid !== 1'b0 || m_if.req_ready !== 1'b1) begin
            bad++; $display("FAIL stall_release got v=%0b rdy=%0b want 0 1", m_if.code_valid, m_if.req_ready);
        end
    endtask

    task automatic test_zero();
        m_if.req = 8'h00; m_if.req_valid = 1'b1; m_if.out_ready = 1'b1;
        total++;
        if (m_if.err_zero !== 1'b0) begin bad++; $display("FAIL zero_pre got err=%0b want 0", m_if.err_zero); end
        @(negedge clk);
        m_if.req_valid = 1'b0;
        total++;
        if (m_if.err_zero !== 1'b1 || m_if.code_valid !== 1'b0 || m_if.req_ready !== 1'b1) begin
            bad++; $display("FAIL zero_pulse got err=%0b v=%0b rdy=%0b want 1 0 1",
                            m_if.err_zero, m_if.code_valid, m_if.req_ready);
        end
        @(negedge clk);
        total++;
        if (m_if.err_zero !== 1'b0 || m_if.code_valid !== 1'b0) begin
            bad++; $display("FAIL zero_after got err=%0b v=%0b want 0 0", m_if.err_zero, m_if.code_valid);
        end
    endtask

    task automatic test_reset_mid();
        m_if.req = 8'hFF; m_if.req_valid = 1'b1; m_if.out_ready = 1'b1;
        @(negedge clk);
        m_if.req_valid = 1'b0;
        total++;
        if (m_if.code !== 3'd7 || m_if.code_valid !== 1'b1) begin
            bad++; $display("FAIL rmid_first got v=%0b code=%0d want 1 7", m_if.code_valid, m_if.code);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (m_if.code_valid !== 1'b0 || m_if.code !== 3'd0 || m_if.last !== 1'b0 ||
            m_if.err_zero !== 1'b0 || m_if.req_ready !== 1'b1) begin
            bad++; $display("FAIL rmid_async got v=%0b code=%0d last=%0b err=%0b rdy=%0b want 0 0 0 0 1",
                            m_if.code_valid, m_if.code, m_if.last, m_if.err_zero, m_if.req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (m_if.code_valid !== 1'b0 || m_if.req_ready !== 1'b1) begin
                bad++; $display("FAIL rmid_after cycle=%0d got v=%0b rdy=%0b want 0 1",
                                c, m_if.code_valid, m_if.req_ready);
            end
        end
    endtask

    task automatic test_ignore_in_emit();
        m_if.req = 8'h0C; m_if.req_valid = 1'b1; m_if.out_ready = 1'b1;
        @(negedge clk);
        m_if.req = 8'h01;
        total++;
        if (m_if.code !== 3'd3 || m_if.code_valid !== 1'b1) begin
            bad++; $display("FAIL ign_first got v=%0b code=%0d want 1 3", m_if.code_valid, m_if.code);
        end
        @(negedge clk);
        total++;
        if (m_if.code !== 3'd2 || m_if.last !== 1'b1) begin
            bad++; $display("FAIL ign_second got code=%0d last=%0b want 2 1", m_if.code, m_if.last);
        end
        @(negedge clk);
        total++;
        if (m_if.code_valid !== 1'b0 || m_if.req_ready !== 1'b1) begin
            bad++; $display("FAIL ign_bubble got v=%0b rdy=%0b want 0 1", m_if.code_valid, m_if.req_ready);
        end
        @(negedge clk);
        m_if.req_valid = 1'b0;
        total++;
        if (m_if.code_valid !== 1'b1 || m_if.code !== 3'd0 || m_if.last !== 1'b1) begin
            bad++; $display("FAIL ign_late got v=%0b code=%0d last=%0b want 1 0 1",
                            m_if.code_valid, m_if.code, m_if.last);
        end
        @(negedge clk);
        total++;
        if (m_if.code_valid !== 1'b0 || m_if.req_ready !== 1'b1) begin
            bad++; $display("FAIL ign_end got v=%0b rdy=%0b want 0 1", m_if.code_valid, m_if.req_ready);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        m_if.req = '0; m_if.req_valid = 1'b0; m_if.out_ready = 1'b0;
        l_if.req = '0; l_if.req_valid = 1'b0; l_if.out_ready = 1'b0;
        test_reset();
        test_msb_order();
        test_lsb_order();
        test_stall();
        test_zero();
        test_reset_mid();
        test_ignore_in_emit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
